// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divider: operation encodings and small op-decode helpers.
package div_unit_pkg;

  localparam int DIV_OP_WIDTH = 2;

  // Low two bits of funct3 for DIV/DIVU/REM/REMU.
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

  function automatic logic is_signed_op(input logic [DIV_OP_WIDTH-1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [DIV_OP_WIDTH-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multicycle radix-2 restoring divider for DIV/DIVU/REM/REMU, with sign fix and RISC-V special cases.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete without iterating.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    div_valid,
  input  logic [DIV_OP_WIDTH-1:0] div_op,
  input  logic [XLEN-1:0]         a,
  input  logic [XLEN-1:0]         b,
  output logic [XLEN-1:0]         result,
  output logic                    div_ready,
  output logic [1:0]              dbg_state
);

  // Handshake: div_valid is held high with stable operands until div_ready; div_ready is a
  // one-cycle pulse with result valid in that cycle. Dropping div_valid while busy aborts.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(XLEN + 1);

  state_e                  state_q, state_d;
  logic [DIV_OP_WIDTH-1:0] op_q, op_d;
  logic [XLEN-1:0]         a_q, a_d;
  logic [XLEN-1:0]         bmag_q, bmag_d;
  logic [XLEN-1:0]         quo_q, quo_d;
  logic [XLEN-1:0]         rem_q, rem_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    quo_neg_q, quo_neg_d;
  logic                    rem_neg_q, rem_neg_d;
  logic                    bzero_q, bzero_d;
  logic                    ovf_q, ovf_d;
  logic [XLEN-1:0]         result_q, result_d;
  logic                    div_ready_q, div_ready_d;

  logic            a_neg, b_neg, in_bzero, in_ovf;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] q_fix, r_fix, final_res;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    bmag_d      = bmag_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    bzero_d     = bzero_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    div_ready_d = 1'b0;

    a_neg    = is_signed_op(div_op) & a[XLEN-1];
    b_neg    = is_signed_op(div_op) & b[XLEN-1];
    in_bzero = (b == '0);
    in_ovf   = is_signed_op(div_op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

    // One restoring step: shift {rem,quo} left and subtract the divisor magnitude.
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, bmag_q};

    q_fix = quo_neg_q ? -quo_q : quo_q;
    r_fix = rem_neg_q ? -rem_q : rem_q;
    case (op_q)
      DIV_OP_DIV:  final_res = q_fix;
      DIV_OP_DIVU: final_res = quo_q;
      DIV_OP_REM:  final_res = r_fix;
      default:     final_res = rem_q;
    endcase
    if (bzero_q) begin
      final_res = is_rem_op(op_q) ? a_q : '1;
    end else if (ovf_q) begin
      final_res = is_rem_op(op_q) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    case (state_q)
      IDLE: begin
        // The request is still high in the cycle after completion; it must not re-trigger.
        if (div_valid && !div_ready_q) begin
          op_d      = div_op;
          a_d       = a;
          quo_d     = a_neg ? -a : a;
          bmag_d    = b_neg ? -b : b;
          rem_d     = '0;
          cnt_d     = CNT_W'(XLEN);
          quo_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          bzero_d   = in_bzero;
          ovf_d     = in_ovf;
`ifdef DIV_FAST_SPECIAL_EN
          state_d   = (in_bzero || in_ovf) ? DONE : BUSY;
`else
          state_d   = BUSY;
`endif
        end
      end
      BUSY: begin
        if (!div_valid) begin
          state_d = IDLE;
        end else begin
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
          end else begin
            rem_d = shifted[XLEN-1:0];
          end
          quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        div_ready_d = 1'b1;
        result_d    = final_res;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      bmag_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      bzero_q     <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      div_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      bmag_q      <= bmag_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      bzero_q     <= bzero_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      div_ready_q <= div_ready_d;
    end
  end

  assign result    = result_q;
  assign div_ready = div_ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, abort/reset/back-to-back, random ops.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              div_valid = 1'b0;
  logic [1:0]        div_op = 2'd0;
  logic [XLEN-1:0]   a = '0;
  logic [XLEN-1:0]   b = '0;
  logic [XLEN-1:0]   result;
  logic              div_ready;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_result = '0;

  div_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .div_valid (div_valid),
    .div_op    (div_op),
    .a         (a),
    .b         (b),
    .result    (result),
    .div_ready (div_ready),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built on the simulator's own signed/unsigned arithmetic.
  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y);
    int sx;
    int sy;
    bit ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (op)
      DIV_OP_DIV:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sx / sy);
      DIV_OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      DIV_OP_REM:  return (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
      default:     return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [XLEN-1:0] x,
                                     input logic [XLEN-1:0] y);
    bit special;
    special = (y == 0) || ((op == DIV_OP_DIV || op == DIV_OP_REM) &&
                           (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF));
`ifdef DIV_FAST_SPECIAL_EN
    return special ? 1 : LAT;
`else
    return special ? LAT : LAT;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle index 0 is the accept edge; scrambles operands mid-operation to prove they are latched.
  task automatic wait_ready(input int budget, input bit scramble, output int lat, output bit seen);
    lat  = -1;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      lat++;
      if (div_ready) begin
        seen = 1'b1;
        break;
      end
      if (scramble && lat == 2) begin
        a = $urandom;
        b = $urandom;
      end
    end
  endtask

  task automatic collect(input string tag, input int exp_lat, input bit scramble);
    int lat;
    bit seen;
    logic [XLEN-1:0] exp;
    wait_ready(exp_lat + 8, scramble, lat, seen);
    exp = exp_q.pop_front();
    if (!seen) begin
      check({tag, " timeout"}, 32'(div_ready), 32'd1);
    end else begin
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, result, exp);
      last_result = exp;
    end
    div_valid = 1'b0;
    tick();
    check({tag, " pulse_width"}, 32'(div_ready), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [XLEN-1:0] x,
                        input logic [XLEN-1:0] y);
    exp_q.push_back(model(op, x, y));
    div_op    = op;
    a         = x;
    b         = y;
    div_valid = 1'b1;
    collect(tag, exp_latency(op, x, y), 1'b1);
    tick();
  endtask

  initial begin
    int pulses;
    int pulse_at[2];
    logic [1:0] rop;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;

    // Reset
    resetn = 1'b0;
    repeat (3) tick();
    check("reset result", result, 32'h0);
    check("reset ready", 32'(div_ready), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    resetn = 1'b1;
    tick();

    // Directed cases
    run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7);
    run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7);
    run_op("div_m7_2",   DIV_OP_DIV,  -32'sd7, 32'd2);
    run_op("rem_m7_2",   DIV_OP_REM,  -32'sd7, 32'd2);
    run_op("rem_7_m2",   DIV_OP_REM,  32'd7,   -32'sd2);
    run_op("div_5_0",    DIV_OP_DIV,  32'd5,   32'd0);
    run_op("remu_5_0",   DIV_OP_REMU, 32'd5,   32'd0);
    run_op("rem_m5_0",   DIV_OP_REM,  -32'sd5, 32'd0);
    run_op("div_ovf",    DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",    DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_big",   DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1);

    // Abort: drop the request mid-operation; no pulse, result untouched.
    div_op    = DIV_OP_DIVU;
    a         = 32'd1000;
    b         = 32'd3;
    div_valid = 1'b1;
    repeat (10) tick();
    div_valid = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (div_ready) pulses++;
    end
    check("abort no_ready", 32'(pulses), 32'd0);
    check("abort result_held", result, last_result);
    check("abort state_idle", 32'(dbg_state), 32'd0);
    run_op("divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3);

    // Reset in the middle of a signed divide; the held request restarts it.
    div_op    = DIV_OP_DIV;
    a         = -32'sd100;
    b         = 32'd7;
    div_valid = 1'b1;
    repeat (6) tick();
    resetn = 1'b0;
    tick();
    check("midreset ready", 32'(div_ready), 32'd0);
    check("midreset result", result, 32'h0);
    check("midreset state", 32'(dbg_state), 32'd0);
    resetn = 1'b1;
    exp_q.push_back(model(DIV_OP_DIV, -32'sd100, 32'd7));
    collect("midreset restart", LAT, 1'b0);
    tick();

    // Back-to-back: request held high, one pulse per accept.
    div_op    = DIV_OP_DIVU;
    a         = 32'd1000;
    b         = 32'd7;
    div_valid = 1'b1;
    exp_q.push_back(model(DIV_OP_DIVU, 32'd1000, 32'd7));
    exp_q.push_back(model(DIV_OP_DIVU, 32'd1000, 32'd7));
    pulses      = 0;
    pulse_at[0] = -1;
    pulse_at[1] = -1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (div_ready) begin
        if (pulses < 2) pulse_at[pulses] = i;
        pulses++;
        if (exp_q.size() > 0) check("b2b result", result, exp_q.pop_front());
        else check("b2b extra_pulse", 32'(div_ready), 32'd0);
      end
    end
    div_valid = 1'b0;
    exp_q.delete();
    check("b2b pulse_count", 32'(pulses), 32'd2);
    check("b2b first_pulse", 32'(pulse_at[0]), 32'(LAT));
    check("b2b second_pulse", 32'(pulse_at[1]), 32'(2 * LAT + 2));
    repeat (3) tick();

    // Random operations
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'($urandom_range(1, 15));
        1:       rb = -32'($urandom_range(1, 5));
        2:       rb = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op("random", rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
